// File: rtl/interface_hcsr04_uc.sv
// HC-SR04 measurement control unit: emits the trigger pulse, gates the synchronised echo
// to contador_cm, latches the BCD result and flags a sensor timeout.
module interface_hcsr04_uc #(
    parameter int unsigned TRIG_CYCLES    = 500,
    parameter int unsigned TIMEOUT_CYCLES = 1_500_000,
    parameter int unsigned TIMEOUT_W      = 21
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        medir,
    input  logic        echo,
    input  logic        fim_medida,
    input  logic [11:0] medida_bcd,
    output logic        trigger,
    output logic        pulso_cm,
    output logic [11:0] medida,
    output logic        pronto,
    output logic        erro,
    output logic [3:0]  db_estado
);

    localparam int unsigned TRIG_W = (TRIG_CYCLES > 1) ? $clog2(TRIG_CYCLES) : 1;
    localparam logic [TRIG_W-1:0]    TRIG_LAST    = TRIG_W'(TRIG_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        StInicial  = 4'd0,
        StPrepara  = 4'd1,
        StTrigger  = 4'd2,
        StEspera   = 4'd3,
        StMedindo  = 4'd4,
        StAguarda  = 4'd5,
        StArmazena = 4'd6,
        StFinal    = 4'd7,
        StTimeout  = 4'd8
    } state_e;

    state_e               state_q, state_d;
    logic [TRIG_W-1:0]    trig_cnt_q, trig_cnt_d;
    logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic                 echo_s1_q, echo_s1_d;
    logic                 echo_s_q, echo_s_d;
    logic                 trigger_q, trigger_d;
    logic                 pronto_q, pronto_d;
    logic                 erro_q, erro_d;
    logic [11:0]          medida_q, medida_d;
    logic                 tmo_hit;
    logic                 echo_rise;

    always_comb begin
        state_d    = state_q;
        trig_cnt_d = trig_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        echo_s1_d  = echo;
        echo_s_d   = echo_s1_q;
        medida_d   = medida_q;
        erro_d     = erro_q;

        tmo_hit   = (tmo_cnt_q == TIMEOUT_LAST);
        // echo_s is about to rise on this edge, so MEDINDO starts together with echo_s high
        echo_rise = echo_s1_q & ~echo_s_q;

        case (state_q)
            StInicial: begin
                if (medir) state_d = StPrepara;
            end
            StPrepara: begin
                trig_cnt_d = '0;
                tmo_cnt_d  = '0;
                state_d    = StTrigger;
            end
            StTrigger: begin
                if (trig_cnt_q == TRIG_LAST) begin
                    state_d = StEspera;
                end else begin
                    trig_cnt_d = trig_cnt_q + 1'b1;
                end
            end
            StEspera: begin
                if (tmo_hit) begin
                    state_d = StTimeout;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                    if (echo_rise) state_d = StMedindo;
                end
            end
            StMedindo: begin
                if (tmo_hit) begin
                    state_d = StTimeout;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                    if (!echo_s_q) state_d = StAguarda;
                end
            end
            StAguarda: begin
                if (tmo_hit) begin
                    state_d = StTimeout;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                    if (fim_medida) state_d = StArmazena;
                end
            end
            StArmazena: begin
                medida_d = medida_bcd;
                state_d  = StFinal;
            end
            StFinal:   state_d = StInicial;
            StTimeout: state_d = StInicial;
            default:   state_d = StInicial;
        endcase

        // Flags follow the state being entered so they line up with pronto
        if (state_d == StPrepara) erro_d = 1'b0;
        if (state_d == StTimeout) erro_d = 1'b1;
        trigger_d = (state_d == StTrigger);
        pronto_d  = (state_d == StFinal) || (state_d == StTimeout);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StInicial;
            trig_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            echo_s1_q  <= 1'b0;
            echo_s_q   <= 1'b0;
            trigger_q  <= 1'b0;
            pronto_q   <= 1'b0;
            erro_q     <= 1'b0;
            medida_q   <= '0;
        end else begin
            state_q    <= state_d;
            trig_cnt_q <= trig_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            echo_s1_q  <= echo_s1_d;
            echo_s_q   <= echo_s_d;
            trigger_q  <= trigger_d;
            pronto_q   <= pronto_d;
            erro_q     <= erro_d;
            medida_q   <= medida_d;
        end
    end

    assign trigger   = trigger_q;
    assign pulso_cm  = (state_q == StMedindo) & echo_s_q;
    assign medida    = medida_q;
    assign pronto    = pronto_q;
    assign erro      = erro_q;
    assign db_estado = state_q;

endmodule

// File: tb/tb_interface_hcsr04_uc.sv
// Bench for interface_hcsr04_uc: randomized echo profiles against a timeline model of one
// measurement, with a small contador_cm stand-in that answers 2 cycles after pulso_cm falls.
module tb_interface_hcsr04_uc;

    localparam int unsigned TRIG = 4;
    localparam int unsigned TMO  = 40;

    logic        clock = 1'b0;
    logic        reset, medir, echo, fim_medida;
    logic [11:0] medida_bcd;
    logic        trigger, pulso_cm, pronto, erro;
    logic [11:0] medida;
    logic [3:0]  db_estado;

    int          total = 0;
    int          bad = 0;
    logic [11:0] medida_exp = '0;

    always #5 clock = ~clock;

    interface_hcsr04_uc #(
        .TRIG_CYCLES   (TRIG),
        .TIMEOUT_CYCLES(TMO),
        .TIMEOUT_W     (21)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .medir     (medir),
        .echo      (echo),
        .fim_medida(fim_medida),
        .medida_bcd(medida_bcd),
        .trigger   (trigger),
        .pulso_cm  (pulso_cm),
        .medida    (medida),
        .pronto    (pronto),
        .erro      (erro),
        .db_estado (db_estado)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Raw echo level in wait-cycle i (i=0 is the first cycle after trigger falls)
    function automatic logic echo_at(input bit pre, input int drop, input int a, input int w,
                                     input int i);
        return (pre && (drop < 0 || i < drop)) || (i >= a && i < a + w);
    endfunction

    function automatic logic [11:0] rand_bcd();
        return {4'($urandom_range(9)), 4'($urandom_range(9)), 4'($urandom_range(9))};
    endfunction

    task automatic do_reset(input string tag);
        #2 reset = 1'b1;
        #1;
        check_eq({tag, "trig"},   32'(trigger),   32'd0);
        check_eq({tag, "pulso"},  32'(pulso_cm),  32'd0);
        check_eq({tag, "estado"}, 32'(db_estado), 32'd0);
        check_eq({tag, "medida"}, 32'(medida),    32'd0);
        check_eq({tag, "erro"},   32'(erro),      32'd0);
        medir      = 1'b0;
        echo       = 1'b0;
        fim_medida = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        medida_exp = '0;
        repeat (3) @(negedge clock);
    endtask

    // One measurement. pre: echo high before medir, dropping at wait-cycle drop (<0: never).
    // Echo pulse covers wait-cycles [a, a+w); w>=100 means it outlasts the timeout.
    // rst_mode: 0 none, 1 reset during TRIGGER, 2 reset during MEDINDO.
    task automatic run_meas(input bit pre, input int drop, input int a, input int w,
                            input bit extra, input int rst_mode, input logic [11:0] bcd);
        int          trig_n, pulso_n, pronto_n, pronto_at, fim_at, exp_at, exp_pulso;
        bit          seen, prev_p, ok, done;
        logic [11:0] med_at;
        logic        erro_at;
        trig_n = 0; pulso_n = 0; pronto_n = 0; pronto_at = -1; fim_at = -1;
        seen = 1'b0; prev_p = 1'b0; done = 1'b0; med_at = '0; erro_at = 1'b0;
        medida_bcd = bcd;
        echo = pre;
        repeat (3) @(negedge clock);
        medir = 1'b1;
        @(negedge clock);
        medir = 1'b0;
        for (int k = 0; k < 12 && !done; k++) begin
            if (trigger) begin
                trig_n++;
                seen = 1'b1;
                if (rst_mode == 1 && trig_n == 2) begin
                    do_reset("rst_trig_");
                    return;
                end
                @(negedge clock);
            end else if (seen) begin
                done = 1'b1;
            end else begin
                @(negedge clock);
            end
        end
        check_eq("trig_len", 32'(trig_n), 32'(TRIG));
        check_eq("st_espera", 32'(db_estado), 32'd3);
        check_eq("erro_clr", 32'(erro), 32'd0);

        done = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            if (pulso_cm) begin
                pulso_n++;
                if (rst_mode == 2) begin
                    do_reset("rst_med_");
                    return;
                end
            end
            if (pronto) begin
                pronto_n++;
                if (pronto_at < 0) begin
                    pronto_at = i;
                    med_at    = medida;
                    erro_at   = erro;
                end
            end
            if (pronto_at >= 0 && i == pronto_at + 2) begin
                check_eq("idle_after", 32'(db_estado), 32'd0);
                done = 1'b1;
            end
            if (prev_p && !pulso_cm) fim_at = i + 2;
            prev_p     = pulso_cm;
            fim_medida = (i == fim_at);
            echo       = echo_at(pre, drop, a, w, i);
            medir      = extra && (i == a + 3);
            @(negedge clock);
        end
        fim_medida = 1'b0;
        echo       = 1'b0;
        medir      = 1'b0;

        // Echo_s trails echo by 2, so pulso_cm spans [a+2, a+w+1]; fim follows at a+w+4,
        // FINAL at a+w+6. Any wait cycle reaching count 39 loses to the timeout.
        ok = (w > 0) && (w < 100) && (a + w + 4 <= int'(TMO) - 2) &&
             (!pre || (drop >= 0 && a > drop));
        exp_at    = ok ? a + w + 6 : int'(TMO);
        exp_pulso = ok ? w : ((!pre && w >= 100) ? int'(TMO) - 2 - a : 0);
        check_eq("pronto_at", 32'(pronto_at), 32'(exp_at));
        check_eq("pronto_len", 32'(pronto_n), 32'd1);
        check_eq("pulso_len", 32'(pulso_n), 32'(exp_pulso));
        check_eq("erro", 32'(erro_at), 32'(!ok));
        check_eq("medida", 32'(med_at), 32'(ok ? bcd : medida_exp));
        if (ok) medida_exp = bcd;
    endtask

    initial begin
        reset = 1'b0; medir = 1'b0; echo = 1'b0; fim_medida = 1'b0; medida_bcd = '0;
        #1 reset = 1'b1;
        #2;
        check_eq("rst_trig",   32'(trigger),   32'd0);
        check_eq("rst_pulso",  32'(pulso_cm),  32'd0);
        check_eq("rst_medida", 32'(medida),    32'd0);
        check_eq("rst_pronto", 32'(pronto),    32'd0);
        check_eq("rst_erro",   32'(erro),      32'd0);
        check_eq("rst_estado", 32'(db_estado), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        run_meas(1'b0, -1, 10, 8,   1'b0, 0, 12'h025);
        run_meas(1'b0, -1, 0,  0,   1'b0, 0, 12'h314);
        run_meas(1'b0, -1, 5,  100, 1'b0, 0, 12'h777);
        run_meas(1'b1, -1, 0,  0,   1'b0, 0, 12'h123);
        run_meas(1'b1, 6,  12, 5,   1'b0, 0, 12'h456);
        run_meas(1'b0, -1, 0,  0,   1'b0, 0, 12'h999);
        run_meas(1'b0, -1, 10, 8,   1'b1, 0, 12'h025);
        run_meas(1'b0, -1, 0,  0,   1'b0, 1, 12'h111);
        run_meas(1'b0, -1, 3,  8,   1'b0, 2, 12'h222);
        run_meas(1'b0, -1, 10, 8,   1'b0, 0, 12'h025);
        run_meas(1'b0, -1, 0,  0,   1'b0, 0, 12'h888);

        for (int n = 0; n < 24; n++) begin
            int kind, a, w, d;
            kind = int'($urandom_range(3));
            a    = int'($urandom_range(20));
            w    = 1 + int'($urandom_range(11));
            d    = int'($urandom_range(8));
            case (kind)
                0:       run_meas(1'b0, -1, a, w, bit'($urandom_range(1)), 0, rand_bcd());
                1:       run_meas(1'b0, -1, 0, 0, 1'b0, 0, rand_bcd());
                2:       run_meas(1'b0, -1, a, 100, 1'b0, 0, rand_bcd());
                default: run_meas(1'b1, d, d + 1 + int'($urandom_range(10)), w, 1'b0, 0,
                                  rand_bcd());
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
